// File: rtl/soc_pm_analog_cfg_loader_if.sv
// Pixel-matrix analog configuration bundle: 128 bits of bias/DAC settings
// driven by the SoC register block.
interface soc_pm_analog_config;
  logic [37:0] res;
  logic [7:0]  th_high;
  logic [7:0]  th_low;
  logic [7:0]  ikrum;
  logic [7:0]  vblr;
  logic [7:0]  fed_csa;
  logic [7:0]  idiscr;
  logic [7:0]  ref_csa_in;
  logic [7:0]  ref_csa_mid;
  logic [7:0]  ref_csa_out;
  logic [5:0]  ref_dac;
  logic [3:0]  ref_dac_base;
  logic [3:0]  ref_dac_krum;
  logic [1:0]  shift_high;
  logic [1:0]  shift_low;

  modport master (
    output res, th_high, th_low, ikrum, vblr, fed_csa, idiscr, ref_csa_in,
           ref_csa_mid, ref_csa_out, ref_dac, ref_dac_base, ref_dac_krum,
           shift_high, shift_low
  );

  modport slave (
    input res, th_high, th_low, ikrum, vblr, fed_csa, idiscr, ref_csa_in,
          ref_csa_mid, ref_csa_out, ref_dac, ref_dac_base, ref_dac_krum,
          shift_high, shift_low
  );
endinterface

// File: rtl/soc_pm_analog_cfg_loader.sv
// Snapshots the analog config on start and shifts it MSB-first into the matrix
// bias/DAC chain on a divided serial clock, then strobes ana_load.
module soc_pm_analog_cfg_loader #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  soc_pm_analog_config.slave        cfg,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      ana_sclk,
  output logic                      ana_sdin,
  output logic                      ana_load
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t       state, state_next;
  logic [127:0] sreg, sreg_next;
  logic [6:0]   bit_cnt, bit_cnt_next;
  logic [7:0]   div_cnt, div_cnt_next;
  logic         busy_next, done_next, sclk_next, sdin_next, load_next;
  logic [127:0] snapshot;
  logic         div_wrap;

  assign snapshot = {cfg.res, cfg.th_high, cfg.th_low, cfg.ikrum, cfg.vblr,
                     cfg.fed_csa, cfg.idiscr, cfg.ref_csa_in, cfg.ref_csa_mid,
                     cfg.ref_csa_out, cfg.ref_dac, cfg.ref_dac_base,
                     cfg.ref_dac_krum, cfg.shift_high, cfg.shift_low};

  assign div_wrap = (div_cnt == DIV_LAST);

  always_comb begin
    state_next   = state;
    sreg_next    = sreg;
    bit_cnt_next = bit_cnt;
    div_cnt_next = div_wrap ? '0 : div_cnt + 8'd1;

    unique case (state)
      IDLE: begin
        div_cnt_next = '0;
        if (start) begin
          sreg_next    = snapshot;
          bit_cnt_next = '0;
          state_next   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_wrap) state_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (div_wrap) begin
          sreg_next    = {sreg[126:0], 1'b0};
          bit_cnt_next = bit_cnt + 7'd1;
          state_next   = (bit_cnt == 7'd127) ? LATCH : SHIFT_LO;
        end
      end
      LATCH: begin
        if (div_wrap) state_next = DONE;
      end
      DONE: begin
        div_cnt_next = '0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so every pin is a flop and
    // lines up with the state it belongs to.
    busy_next = (state_next == SHIFT_LO) || (state_next == SHIFT_HI) ||
                (state_next == LATCH);
    done_next = (state_next == DONE);
    sclk_next = (state_next == SHIFT_HI);
    load_next = (state_next == LATCH);

    sdin_next = ana_sdin;
    if (state_next == IDLE)          sdin_next = 1'b0;
    else if (state_next == SHIFT_LO) sdin_next = sreg_next[127];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ana_sclk <= 1'b0;
      ana_sdin <= 1'b0;
      ana_load <= 1'b0;
    end else begin
      state    <= state_next;
      sreg     <= sreg_next;
      bit_cnt  <= bit_cnt_next;
      div_cnt  <= div_cnt_next;
      busy     <= busy_next;
      done     <= done_next;
      ana_sclk <= sclk_next;
      ana_sdin <= sdin_next;
      ana_load <= load_next;
    end
  end

endmodule

// File: tb/tb_soc_pm_analog_cfg_loader.sv
// Directed + random bench: four loaders (CLK_DIV 4,1,3,7), a behavioural
// analog chain per loader, and a snapshot scoreboard.
module tb_soc_pm_analog_cfg_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   start = '0;
  logic [3:0]   busy, done, sclk, sdin, load;
  logic [127:0] cfg_vec = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc [4] = '{default: 0};

  logic [127:0] chain   [4];
  logic [127:0] latched [4];
  int rise_tot  [4] = '{default: 0};
  int load_tot  [4] = '{default: 0};
  int rise_gap  [4] = '{default: 0};
  int last_rise [4] = '{default: 0};
  int ld_first  [4] = '{default: 0};
  int ld_last   [4] = '{default: 0};
  int done_rel  [4] = '{default: 0};
  int unstable  [4] = '{default: 0};
  logic [3:0] sclk_p = '0, load_p = '0, sdin_p = '0;

  logic [127:0] sb [$];

  for (genvar k = 0; k < 4; k++) begin : g
    soc_pm_analog_config cfg_if ();
    assign cfg_if.res          = cfg_vec[127:90];
    assign cfg_if.th_high      = cfg_vec[89:82];
    assign cfg_if.th_low       = cfg_vec[81:74];
    assign cfg_if.ikrum        = cfg_vec[73:66];
    assign cfg_if.vblr         = cfg_vec[65:58];
    assign cfg_if.fed_csa      = cfg_vec[57:50];
    assign cfg_if.idiscr       = cfg_vec[49:42];
    assign cfg_if.ref_csa_in   = cfg_vec[41:34];
    assign cfg_if.ref_csa_mid  = cfg_vec[33:26];
    assign cfg_if.ref_csa_out  = cfg_vec[25:18];
    assign cfg_if.ref_dac      = cfg_vec[17:12];
    assign cfg_if.ref_dac_base = cfg_vec[11:8];
    assign cfg_if.ref_dac_krum = cfg_vec[7:4];
    assign cfg_if.shift_high   = cfg_vec[3:2];
    assign cfg_if.shift_low    = cfg_vec[1:0];

    soc_pm_analog_cfg_loader #(
      .CLK_DIV(k == 0 ? 4 : (k == 1 ? 1 : (k == 2 ? 3 : 7)))
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg      (cfg_if),
      .start    (start[k]),
      .busy     (busy[k]),
      .done     (done[k]),
      .ana_sclk (sclk[k]),
      .ana_sdin (sdin[k]),
      .ana_load (load[k])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain model: shift on sclk rise, parallel latch on ana_load rise.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (sclk[k] && !sclk_p[k]) begin
        chain[k]     <= {chain[k][126:0], sdin[k]};
        rise_tot[k]  <= rise_tot[k] + 1;
        rise_gap[k]  <= cyc - last_rise[k];
        last_rise[k] <= cyc;
        if (sdin[k] !== sdin_p[k]) unstable[k] <= unstable[k] + 1;
      end
      if (load[k] && !load_p[k]) begin
        latched[k]  <= chain[k];
        load_tot[k] <= load_tot[k] + 1;
        ld_first[k] <= cyc - start_cyc[k];
      end
      if (load[k]) ld_last[k]  <= cyc - start_cyc[k];
      if (done[k]) done_rel[k] <= cyc - start_cyc[k];
    end
    sclk_p <= sclk;
    load_p <= load;
    sdin_p <= sdin;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk);
    start_cyc[k] = cyc;
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int dcyc);
    bit seen = 1'b0;
    dcyc = 0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      if (done[k]) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    check("done_seen", 128'(seen), 128'd1);
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic load_and_check(input int k, input logic [127:0] vec, input string tag);
    int d;
    int r0;
    r0 = rise_tot[k];
    cfg_vec = vec;
    sb.push_back(vec);
    pulse_start(k);
    wait_done(k, d);
    check(tag, latched[k], sb.pop_front());
    check({tag, "_bits"}, 128'(rise_tot[k] - r0), 128'd128);
  endtask

  initial begin
    int d1, d2, r0, l0;
    logic [127:0] a_vec, b_vec;

    wait_cycles(3);
    check("reset_outputs", {busy, done, sclk, sdin, load}, '0);
    rst = 1'b0;
    wait_cycles(2);
    check("idle_outputs", {busy, done, sclk, sdin, load}, '0);

    // Reset in the middle of SHIFT_HI for bit 40.
    r0 = rise_tot[0];
    l0 = load_tot[0];
    cfg_vec = {$urandom, $urandom, $urandom, $urandom};
    sb.push_back(cfg_vec);
    pulse_start(0);
    for (int n = 0; n < 1000 && (rise_tot[0] - r0) < 41; n++) @(negedge clk);
    check("t1_at_bit40", 128'(rise_tot[0] - r0), 128'd41);
    check("t1_in_shift_hi", 128'({busy[0], sclk[0]}), 128'b11);
    #1 rst = 1'b1;
    #1 check("t1_reset_outputs", {busy, done, sclk, sdin, load}, '0);
    void'(sb.pop_front());
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(20);
    check("t1_no_load", 128'(load_tot[0] - l0), 128'd0);
    load_and_check(0, {$urandom, $urandom, $urandom, $urandom}, "t1_full_load");

    // Alternating res pattern plus timing of load strobe and done.
    load_and_check(0, {38'h2A_AAAA_AAAA, 90'd0}, "t2_pattern");
    check("t2_ld_first", 128'(ld_first[0]), 128'd1025);
    check("t2_ld_last", 128'(ld_last[0]), 128'd1028);
    check("t2_done_rel", 128'(done_rel[0]), 128'd1029);
    check("t2_sclk_period", 128'(rise_gap[0]), 128'd8);

    // Walking one in th_high lands on shifted bit 38.
    load_and_check(0, {38'd0, 8'h80, 82'd0}, "t3_th_high");
    check("t3_bit38", 128'(latched[0][127-38]), 128'd1);

    // Final data bit held through LATCH, cleared in IDLE.
    cfg_vec = 128'd1;
    sb.push_back(cfg_vec);
    pulse_start(0);
    for (int n = 0; n < 1200 && !load[0]; n++) @(negedge clk);
    check("sdin_hold_latch", 128'({load[0], sdin[0]}), 128'b11);
    wait_done(0, d1);
    check("sdin_hold_load", latched[0], sb.pop_front());
    check("sdin_idle_zero", 128'({busy[0], sdin[0]}), 128'b00);

    // Cfg changes and start pulses during a load are ignored.
    a_vec = {$urandom, $urandom, $urandom, $urandom};
    b_vec = ~a_vec;
    l0 = load_tot[0];
    cfg_vec = a_vec;
    sb.push_back(a_vec);
    pulse_start(0);
    for (int n = 0; n < 20 && (cyc - start_cyc[0]) < 5; n++) @(negedge clk);
    cfg_vec = b_vec;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int n = 0; n < 600 && (cyc - start_cyc[0]) < 500; n++) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, d1);
    check("t4_snapshot", latched[0], sb.pop_front());
    wait_cycles(30);
    check("t4_single_load", 128'(load_tot[0] - l0), 128'd1);
    check("t4_idle", 128'(busy[0]), 128'd0);

    // CLK_DIV=1 with start held: back-to-back loads every 259 cycles.
    l0 = load_tot[1];
    cfg_vec = {$urandom, $urandom, $urandom, $urandom};
    sb.push_back(cfg_vec);
    sb.push_back(cfg_vec);
    @(negedge clk);
    start_cyc[1] = cyc;
    start[1] = 1'b1;
    wait_done(1, d1);
    check("t5_done_rel", 128'(done_rel[1]), 128'd258);
    check("t5_load1", latched[1], sb.pop_front());
    wait_done(1, d2);
    start[1] = 1'b0;
    check("t5_load2", latched[1], sb.pop_front());
    check("t5_done_period", 128'(d2 - d1), 128'd259);
    check("t5_sclk_period", 128'(rise_gap[1]), 128'd2);
    wait_cycles(300);
    check("t5_load_count", 128'(load_tot[1] - l0), 128'd2);

    // Random configs across CLK_DIV 1, 3, 7.
    for (int i = 0; i < 50; i++) begin
      load_and_check(1 + (i % 3), {$urandom, $urandom, $urandom, $urandom}, "t6_random");
    end

    check("sdin_stable_at_rise",
          128'(unstable[0] + unstable[1] + unstable[2] + unstable[3]), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
